// File: rtl/debug_dump_tx.sv
// Serialises one pipeline-snapshot frame over a byte-wide UART handshake:
// HEADER, payload bytes MSB first, then the XOR checksum of the payload.
module debug_dump_tx #(
  parameter int unsigned         NB_DATA    = 8,
  parameter int unsigned         NB_ID_EX   = 144,
  parameter int unsigned         NB_EX_MEM  = 32,
  parameter int unsigned         NB_MEM_WB  = 48,
  parameter int unsigned         NB_WB_ID   = 40,
  parameter int unsigned         NB_CONTROL = 24,
  parameter logic [NB_DATA-1:0]  HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_send,
  input  logic [NB_ID_EX-1:0]   i_segment_registers_ID_EX,
  input  logic [NB_EX_MEM-1:0]  i_segment_registers_EX_MEM,
  input  logic [NB_MEM_WB-1:0]  i_segment_registers_MEM_WB,
  input  logic [NB_WB_ID-1:0]   i_segment_registers_WB_ID,
  input  logic [NB_CONTROL-1:0] i_control_registers_ID_EX,
  input  logic                  i_txDone,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned NbTotal = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
  localparam int unsigned NbPay   = NbTotal / NB_DATA;
  localparam int unsigned NbFrame = NbPay + 2;
  localparam int unsigned IdxW    = $clog2(NbFrame + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NbFrame - 1);
  localparam logic [IdxW-1:0] PayLast = IdxW'(NbPay);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NB_DATA-1:0] csum_q, csum_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NbTotal-1:0] buf_q, buf_d;
  logic [NB_DATA-1:0] top_byte;

  assign top_byte = buf_q[NbTotal-1 -: NB_DATA];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    data_d  = data_q;
    buf_d   = buf_q;
    case (state_q)
      StIdle: begin
        if (i_send) begin
          buf_d   = {i_segment_registers_ID_EX, i_segment_registers_EX_MEM,
                     i_segment_registers_MEM_WB, i_segment_registers_WB_ID,
                     i_control_registers_ID_EX};
          idx_d   = '0;
          csum_d  = '0;
          data_d  = HEADER;
          state_d = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (i_txDone) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            state_d = StSend;
            // Payload bytes pop off the top of the buffer; the byte after them is the checksum.
            if (idx_q < PayLast) begin
              data_d = top_byte;
              csum_d = csum_q ^ top_byte;
              buf_d  = buf_q << NB_DATA;
            end else begin
              data_d = csum_q;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
    end
  end

  assign o_tx_start = (state_q == StSend);
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);
  assign o_data     = data_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: a frame model fills an expected-byte queue,
// a monitor pops it on every transmit strobe, and a UART stand-in returns txDone.
module tb_debug_dump_tx;

  localparam int unsigned NbData = 8;
  localparam logic [7:0]  Header = 8'hA5;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_send = 1'b0;
  logic [143:0] id_ex = '0;
  logic [31:0]  ex_mem = '0;
  logic [47:0]  mem_wb = '0;
  logic [39:0]  wb_id = '0;
  logic [23:0]  ctrl = '0;
  logic         i_txDone = 1'b0;
  logic         o_tx_start;
  logic [7:0]   o_data;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  debug_dump_tx #(
    .NB_DATA    (NbData),
    .NB_ID_EX   (144),
    .NB_EX_MEM  (32),
    .NB_MEM_WB  (48),
    .NB_WB_ID   (40),
    .NB_CONTROL (24),
    .HEADER     (Header)
  ) dut (
    .clk                        (clk),
    .i_reset                    (i_reset),
    .i_send                     (i_send),
    .i_segment_registers_ID_EX  (id_ex),
    .i_segment_registers_EX_MEM (ex_mem),
    .i_segment_registers_MEM_WB (mem_wb),
    .i_segment_registers_WB_ID  (wb_id),
    .i_control_registers_ID_EX  (ctrl),
    .i_txDone                   (i_txDone),
    .o_tx_start                 (o_tx_start),
    .o_data                     (o_data),
    .o_busy                     (o_busy),
    .o_done                     (o_done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         strobe_cnt = 0;
  int         done_cnt = 0;
  int         fixed_delay = 9;   // 0 selects a random 1..4 cycle txDone delay
  bit         extra_mode = 1'b0; // also pulse txDone during the strobe cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference frame: header, each segment MSB byte first, XOR of payload bytes.
  logic [7:0] model_csum;
  task automatic push_seg(input logic [143:0] v, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((v >> (8 * (nbytes - 1 - i))) & 144'hFF);
      exp_q.push_back(b);
      model_csum ^= b;
    end
  endtask

  task automatic model_frame();
    model_csum = 8'h00;
    exp_q.push_back(Header);
    push_seg(id_ex, 18);
    push_seg(144'(ex_mem), 4);
    push_seg(144'(mem_wb), 6);
    push_seg(144'(wb_id), 5);
    push_seg(144'(ctrl), 3);
    exp_q.push_back(model_csum);
  endtask

  task automatic randomize_snapshots();
    logic [159:0] t;
    t      = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    id_ex  = t[143:0];
    ex_mem = $urandom();
    mem_wb = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF;
    wb_id  = {$urandom(), $urandom()} & 64'hFF_FFFF_FFFF;
    ctrl   = $urandom() & 32'hFF_FFFF;
  endtask

  // Monitor: every strobe consumes one expected byte.
  always begin
    @(posedge clk);
    #1;
    if (o_tx_start) begin
      strobe_cnt++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'(o_tx_start), 32'd0);
      else chk("frame_byte", 32'(o_data), 32'(exp_q.pop_front()));
    end
    if (o_done) begin
      done_cnt++;
      chk("done_with_bytes_left", exp_q.size(), 32'd0);
      chk("busy_during_done", 32'(o_busy), 32'd1);
    end
  end

  // UART stand-in: acknowledges each strobe after a delay.
  initial begin
    forever begin
      if (!o_tx_start) begin
        @(negedge clk);
      end else begin
        int d;
        d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
        i_txDone = extra_mode;
        repeat (d) begin
          @(negedge clk);
          i_txDone = 1'b0;
        end
        i_txDone = 1'b1;
        @(negedge clk);
        i_txDone = 1'b0;
      end
    end
  end

  task automatic send_frame();
    @(negedge clk);
    model_frame();
    i_send = 1'b1;
    @(posedge clk);
    #1;
    chk("header_latency_strobe", 32'(o_tx_start), 32'd1);
    chk("header_latency_data", 32'(o_data), 32'(Header));
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_count", 32'(done_cnt - start), 32'd1);
    @(negedge clk);
    chk("done_single_cycle", 32'(o_done), 32'd0);
    chk("busy_low_after_frame", 32'(o_busy), 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_wait_timeout", 32'(strobe_cnt >= target), 32'd1);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_tx_start", 32'(o_tx_start), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero frame, slow UART.
    fixed_delay = 9;
    send_frame();
    wait_done(1000);

    // EX_MEM pattern and ID_EX ramp.
    fixed_delay = 2;
    ex_mem = 32'hDEADBEEF;
    send_frame();
    wait_done(600);
    ex_mem = '0;
    for (int i = 1; i <= 18; i++) id_ex = (id_ex << 8) | 144'(i);
    send_frame();
    wait_done(600);

    // Random frames with random txDone delay.
    fixed_delay = 0;
    for (int f = 0; f < 4; f++) begin
      randomize_snapshots();
      send_frame();
      wait_done(600);
    end

    // Snapshots change and i_send repeats mid-frame: capture must hold, no second frame.
    randomize_snapshots();
    s0 = strobe_cnt;
    send_frame();
    wait_strobes(s0 + 6, 200);
    @(negedge clk);
    randomize_snapshots();
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    wait_done(600);
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    chk("no_queued_frame", 32'(strobe_cnt - s0), 32'd0);

    // Reset during WAIT of byte 10 aborts the frame.
    fixed_delay = 6;
    randomize_snapshots();
    s0 = strobe_cnt;
    send_frame();
    wait_strobes(s0 + 11, 300);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_tx_start", 32'(o_tx_start), 32'd0);
    i_reset = 1'b0;
    exp_q.delete();
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("abort_stays_idle", 32'(o_busy), 32'd0);
    randomize_snapshots();
    send_frame();
    wait_done(600);

    // txDone in IDLE, then txDone during every strobe cycle.
    i_txDone = 1'b1;
    @(negedge clk);
    i_txDone = 1'b0;
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    chk("idle_txdone_ignored", 32'(strobe_cnt - s0), 32'd0);
    fixed_delay = 3;
    extra_mode = 1'b1;
    randomize_snapshots();
    send_frame();
    wait_done(600);
    extra_mode = 1'b0;

    // i_send together with i_reset.
    i_send = 1'b1;
    i_reset = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    i_reset = 1'b0;
    chk("reset_beats_send", 32'(o_busy), 32'd0);
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    chk("reset_send_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
